// File: rtl/script_pkg.sv
// Shared definitions for the script sequencer: opcodes, action codes,
// instruction field positions and FSM state encoding.
package script_pkg;

    localparam logic [1:0] OP_ACT  = 2'b00;
    localparam logic [1:0] OP_WAIT = 2'b01;
    localparam logic [1:0] OP_JMP  = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    localparam logic [1:0] GET      = 2'd0;
    localparam logic [1:0] PUT      = 2'd1;
    localparam logic [1:0] INTERACT = 2'd2;
    localparam logic [1:0] THROW    = 2'd3;

    localparam int unsigned OP_MSB   = 15;
    localparam int unsigned OP_LSB   = 14;
    localparam int unsigned FUNC_MSB = 13;
    localparam int unsigned FUNC_LSB = 12;
    localparam int unsigned TGT_MSB  = 7;
    localparam int unsigned TGT_LSB  = 0;
    localparam int unsigned CNT_MSB  = 11;
    localparam int unsigned CNT_LSB  = 0;
    localparam int unsigned CNT_W    = CNT_MSB - CNT_LSB + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT_DONE,
        S_DELAY,
        S_HALTED,
        S_ERROR
    } state_t;

endpackage

// File: rtl/script_sequencer_timer.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module seq_timer
    import script_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/script_sequencer.sv
// Script sequencer: fetches 16-bit instructions from a synchronous ROM and
// drives the action block one action at a time, with waits, jumps and halt.
module script_sequencer
    import script_pkg::*;
#(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned TIMEOUT    = 1000000,
    parameter int unsigned WAIT_SCALE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              act_en,
    output logic [1:0]        act_func,
    output logic [7:0]        act_target,
    input  logic              act_done,
    output logic              busy,
    output logic              halted,
    output logic              err_timeout,
    output logic [ADDR_W-1:0] pc
);

    localparam int unsigned     TMO_W    = $clog2(TIMEOUT) + 1;
    localparam int unsigned     DLY_W    = CNT_W + $clog2(WAIT_SCALE) + 1;
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT - 1);

    state_t            state, state_next;
    logic [ADDR_W-1:0] pc_next;
    logic              act_en_next;
    logic [1:0]        act_func_next;
    logic [7:0]        act_target_next;
    logic [1:0]        instr_func, instr_func_next;
    logic [7:0]        instr_target, instr_target_next;

    logic [1:0]        opcode;
    logic [CNT_W-1:0]  wait_count;
    logic [DLY_W-1:0]  dly_value;
    logic              tmo_load, tmo_dec, tmo_zero;
    logic              dly_load, dly_dec, dly_zero;

    // Address is combinational from pc so the ROM word arrives in DECODE.
    assign rom_addr   = pc;
    assign opcode     = rom_data[OP_MSB:OP_LSB];
    assign wait_count = rom_data[CNT_MSB:CNT_LSB];
    // Timer is loaded with N-1 and exits on zero: exactly N DELAY cycles.
    assign dly_value  = DLY_W'(wait_count) * DLY_W'(WAIT_SCALE) - DLY_W'(1);

    assign busy        = !(state inside {S_IDLE, S_HALTED, S_ERROR});
    assign halted      = (state == S_HALTED);
    assign err_timeout = (state == S_ERROR);

    seq_timer #(.WIDTH(TMO_W)) u_tmo_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmo_load),
        .value (TMO_LOAD),
        .dec   (tmo_dec),
        .zero  (tmo_zero)
    );

    seq_timer #(.WIDTH(DLY_W)) u_dly_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (dly_load),
        .value (dly_value),
        .dec   (dly_dec),
        .zero  (dly_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            pc           <= '0;
            act_en       <= 1'b0;
            act_func     <= GET;
            act_target   <= '0;
            instr_func   <= GET;
            instr_target <= '0;
        end else begin
            state        <= state_next;
            pc           <= pc_next;
            act_en       <= act_en_next;
            act_func     <= act_func_next;
            act_target   <= act_target_next;
            instr_func   <= instr_func_next;
            instr_target <= instr_target_next;
        end
    end

    always_comb begin
        state_next        = state;
        pc_next           = pc;
        act_en_next       = act_en;
        act_func_next     = act_func;
        act_target_next   = act_target;
        instr_func_next   = instr_func;
        instr_target_next = instr_target;
        tmo_load          = 1'b0;
        tmo_dec           = 1'b0;
        dly_load          = 1'b0;
        dly_dec           = 1'b0;

        case (state)
            S_IDLE, S_HALTED, S_ERROR: begin
                if (start) begin
                    pc_next    = '0;
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                state_next = S_DECODE;
            end
            S_DECODE: begin
                instr_func_next   = rom_data[FUNC_MSB:FUNC_LSB];
                instr_target_next = rom_data[TGT_MSB:TGT_LSB];
                case (opcode)
                    OP_ACT: state_next = S_ISSUE;
                    OP_WAIT: begin
                        if (wait_count == '0) begin
                            pc_next    = pc + ADDR_W'(1);
                            state_next = S_FETCH;
                        end else begin
                            dly_load   = 1'b1;
                            state_next = S_DELAY;
                        end
                    end
                    OP_JMP: begin
                        pc_next    = rom_data[ADDR_W-1:0];
                        state_next = S_FETCH;
                    end
                    default: state_next = S_HALTED;
                endcase
            end
            S_ISSUE: begin
                act_func_next   = instr_func;
                act_target_next = instr_target;
                act_en_next     = 1'b1;
                tmo_load        = 1'b1;
                state_next      = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                // Completion takes priority over an expiring timeout.
                if (act_done) begin
                    act_en_next = 1'b0;
                    pc_next     = pc + ADDR_W'(1);
                    state_next  = S_FETCH;
                end else if (tmo_zero) begin
                    act_en_next = 1'b0;
                    state_next  = S_ERROR;
                end else begin
                    tmo_dec = 1'b1;
                end
            end
            S_DELAY: begin
                if (dly_zero) begin
                    pc_next    = pc + ADDR_W'(1);
                    state_next = S_FETCH;
                end else begin
                    dly_dec = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_script_sequencer.sv
// Scoreboard bench for script_sequencer: a program-level model predicts each
// action (func, target, pc, idle gap) and each action's high time.
module tb_script_sequencer;

    localparam int unsigned AW  = 8;
    localparam int unsigned TMO = 16;
    localparam int unsigned WS  = 1;

    logic          clk = 1'b0;
    logic          rst, start, act_done;
    logic [AW-1:0] rom_addr, pc;
    logic [15:0]   rom_data;
    logic          act_en, busy, halted, err_timeout;
    logic [1:0]    act_func;
    logic [7:0]    act_target;

    always #5 clk = ~clk;

    script_sequencer #(.ADDR_W(AW), .TIMEOUT(TMO), .WAIT_SCALE(WS)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .act_en      (act_en),
        .act_func    (act_func),
        .act_target  (act_target),
        .act_done    (act_done),
        .busy        (busy),
        .halted      (halted),
        .err_timeout (err_timeout),
        .pc          (pc)
    );

    logic [15:0] rom [256];
    always @(posedge clk) rom_data <= rom[rom_addr];

    typedef struct {
        int func;
        int target;
        int pc;
        int gap;
    } exp_t;

    exp_t exp_q[$];
    int   dur_q[$];
    int   total = 0;
    int   passed = 0;

    task automatic check(input string name, input longint got, input longint exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    function automatic logic [15:0] i_act(input int f, input int t);
        logic [1:0] ff;
        logic [7:0] tt;
        ff = f[1:0];
        tt = t[7:0];
        return {2'b00, ff, 4'b0000, tt};
    endfunction

    function automatic logic [15:0] i_wait(input int c);
        logic [11:0] cc;
        cc = c[11:0];
        return {2'b01, 2'b00, cc};
    endfunction

    function automatic logic [15:0] i_jmp(input int d);
        logic [7:0] dd;
        dd = d[7:0];
        return {2'b10, 6'b000000, dd};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'hC000;
    endtask

    // Walks the program at instruction level; each non-action instruction
    // costs FETCH+DECODE (plus its delay), each action adds FETCH+DECODE+ISSUE.
    task automatic model(input int max_act, output int fin_pc);
        int          p, gap, n;
        bit          stop;
        logic [15:0] ins;
        exp_t        e;
        p = 0; gap = 0; n = 0; stop = 0;
        for (int step = 0; step < 5000 && n < max_act && !stop; step++) begin
            ins = rom[p];
            case (ins[15:14])
                2'b00: begin
                    e.func = int'(ins[13:12]); e.target = int'(ins[7:0]);
                    e.pc = p; e.gap = gap + 3;
                    exp_q.push_back(e);
                    gap = 0; n++; p = (p + 1) % 256;
                end
                2'b01: begin
                    gap += 2 + int'(ins[11:0]) * int'(WS);
                    p = (p + 1) % 256;
                end
                2'b10: begin
                    gap += 2; p = int'(ins[7:0]);
                end
                default: stop = 1;
            endcase
        end
        fin_pc = p;
    endtask

    // Game-side responder
    bit no_resp = 0, stale_mode = 0, seen = 0;
    int d;
    initial begin
        act_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (act_en && !seen) begin
                seen = 1; act_done = 1'b0;
                if (no_resp) dur_q.push_back(TMO);
                else begin
                    d = $urandom_range(0, 4);
                    dur_q.push_back(d + 1);
                    repeat (d) begin @(posedge clk); #1; end
                    act_done = 1'b1;
                    @(posedge clk); #1;
                    act_done = 1'b0;
                end
            end else if (!act_en) begin
                seen = 0;
                act_done = stale_mode;
            end
        end
    end

    // Monitor
    bit   mon_on = 0, loop_mode = 0;
    int   gap_cnt = 0, hi_cnt = 0, busy_drops = 0;
    logic prev_en = 1'b0;
    exp_t me;
    always @(negedge clk) begin
        if (mon_on) begin
            if (act_en) begin
                if (!prev_en) begin
                    if (exp_q.size() == 0) check("unexpected_action", 1, 0);
                    else begin
                        me = exp_q.pop_front();
                        check("act_func", act_func, me.func);
                        check("act_target", act_target, me.target);
                        check("act_pc", pc, me.pc);
                        check("idle_gap", gap_cnt, me.gap);
                    end
                    gap_cnt = 0; hi_cnt = 0;
                end
                hi_cnt++;
            end else begin
                if (prev_en) begin
                    if (dur_q.size() == 0) check("unexpected_fall", 1, 0);
                    else check("act_en_high_cycles", hi_cnt, dur_q.pop_front());
                end
                if (busy) gap_cnt++;
            end
            if (loop_mode && !busy) busy_drops++;
        end
        prev_en = act_en;
    end

    task automatic do_start();
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("start_busy", busy, 1);
        check("start_pc", pc, 0);
        check("start_err", err_timeout, 0);
    endtask

    task automatic run_program();
        int fin_pc;
        bit done;
        exp_q.delete(); dur_q.delete();
        model(1000, fin_pc);
        gap_cnt = 0; mon_on = 1;
        do_start();
        done = 0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk); #2;
            if (!busy) done = 1;
            else start = ($urandom_range(0, 15) == 0);
        end
        start = 1'b0;
        check("finished_in_budget", done, 1);
        check("halted", halted, 1);
        check("final_pc", pc, fin_pc);
        check("err_after_halt", err_timeout, 0);
        check("act_en_after_halt", act_en, 0);
        check("actions_left", exp_q.size(), 0);
        check("durations_left", dur_q.size(), 0);
    endtask

    task automatic run_loop(input int n);
        int fin_pc;
        bit done;
        exp_q.delete(); dur_q.delete();
        model(n, fin_pc);
        gap_cnt = 0; busy_drops = 0; mon_on = 1;
        do_start();
        loop_mode = 1;
        done = 0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk); #2;
            if (exp_q.size() == 0 && act_en) done = 1;
            else start = ($urandom_range(0, 7) == 0);
        end
        start = 1'b0;
        check("loop_reached", done, 1);
        check("busy_never_dropped", busy_drops, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        mon_on = 0; loop_mode = 0;
        check("rst_act_en", act_en, 0);
        check("rst_func", act_func, 0);
        check("rst_target", act_target, 0);
        check("rst_pc", pc, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_err", err_timeout, 0);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        exp_q.delete(); dur_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  len, fin_pc;
        bit  done;
        rst = 1'b1; start = 1'b0;
        clear_rom();
        repeat (3) @(posedge clk);
        #1;
        check("reset_act_en", act_en, 0);
        check("reset_func", act_func, 0);
        check("reset_target", act_target, 0);
        check("reset_pc", pc, 0);
        check("reset_rom_addr", rom_addr, 0);
        check("reset_busy", busy, 0);
        check("reset_halted", halted, 0);
        check("reset_err", err_timeout, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        clear_rom();
        rom[0] = i_act(0, 3); rom[1] = i_act(1, 5);
        run_program();

        clear_rom();
        rom[0] = i_act(2, 7); rom[1] = i_wait(10); rom[2] = i_act(3, 9);
        rom[3] = i_wait(0);   rom[4] = i_act(0, 1);
        run_program();

        stale_mode = 1;
        clear_rom();
        rom[0] = i_act(0, 3); rom[1] = i_act(1, 5);
        run_program();
        stale_mode = 0;

        clear_rom();
        rom[0] = i_act(0, 3); rom[1] = i_act(1, 5); rom[2] = i_jmp(0);
        run_loop(5);

        clear_rom();
        rom[0] = i_act(2, 8'h11); rom[1] = i_jmp(254);
        rom[254] = i_act(3, 8'hAA); rom[255] = i_wait(3);
        run_loop(6);

        clear_rom();
        rom[0] = i_act(3, 2);
        exp_q.delete(); dur_q.delete();
        model(1000, fin_pc);
        no_resp = 1; gap_cnt = 0; mon_on = 1;
        do_start();
        done = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk); #2;
            if (!busy) done = 1;
        end
        check("timeout_reached", done, 1);
        repeat (5) @(posedge clk);
        #1;
        check("timeout_err", err_timeout, 1);
        check("timeout_halted", halted, 0);
        check("timeout_act_en", act_en, 0);
        check("timeout_pc", pc, 0);
        check("timeout_actions_left", exp_q.size(), 0);
        check("timeout_durations_left", dur_q.size(), 0);
        no_resp = 0;
        clear_rom();
        rom[0] = i_act(0, 3); rom[1] = i_act(1, 5);
        run_program();

        for (int k = 0; k < 6; k++) begin
            clear_rom();
            len = $urandom_range(3, 10);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) < 3) rom[i] = i_act($urandom_range(0, 3), $urandom_range(0, 255));
                else rom[i] = i_wait($urandom_range(0, 12));
            end
            stale_mode = $urandom_range(0, 1);
            run_program();
        end
        stale_mode = 0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
